// File: rtl/fht_pkg.sv
// Shared constants for the FHT butterfly write-back path.
package fht_pkg;

  localparam int D_BIT_DEF = 17;
  localparam int A_BIT_DEF = 8;
  localparam int BUT_LAT   = 2;

  typedef enum logic {
    HALF0 = 1'b0,
    HALF1 = 1'b1
  } half_e;

endpackage

// File: rtl/fht_wb_fifo.sv
// Small synchronous FIFO holding completed butterfly pairs awaiting write-back.
module fht_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic                     iPUSH,
  input  logic [W-1:0]             iDATA,
  input  logic                     iPOP,
  output logic [W-1:0]             oHEAD,
  output logic [$clog2(DEPTH):0]   oCOUNT,
  output logic                     oEMPTY
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign oEMPTY = (r_count == '0);
  assign w_push = iPUSH && !w_full;
  assign w_pop  = iPOP && !oEMPTY;
  assign oHEAD  = r_mem[r_rdPtr];
  assign oCOUNT = r_count;

  // Storage needs no reset: only entries covered by r_count are ever read.
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= iDATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fht_but_wb.sv
// FHT butterfly write-back: tracks issues through the butterfly latency, buffers
// Y_0/Y_1 pairs and serialises them onto one RAM write port.
module fht_but_wb
  import fht_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF,
  parameter int DEPTH = 4
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iISSUE,
  input  logic                    iLAST,
  input  logic [A_BIT-1:0]        iADDR_0,
  input  logic [A_BIT-1:0]        iADDR_1,
  output logic                    oREADY,
  input  logic signed [D_BIT-1:0] iY_0,
  input  logic signed [D_BIT-1:0] iY_1,
  output logic                    oWR_EN,
  output logic [A_BIT-1:0]        oWR_ADDR,
  output logic signed [D_BIT-1:0] oWR_DATA,
  input  logic                    iWR_READY,
  output logic                    oBUSY,
  output logic                    oDONE
);

  localparam int EW = 2*A_BIT + 2*D_BIT + 1;
  localparam int NW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH) + 2;

  logic [BUT_LAT-1:0] r_pv;
  logic [BUT_LAT-1:0] r_pLast;
  logic [A_BIT-1:0]   r_pAddr0 [BUT_LAT];
  logic [A_BIT-1:0]   r_pAddr1 [BUT_LAT];
  half_e              r_state;
  logic               r_done;

  logic               w_accept;
  logic [CW-1:0]      w_credit;
  logic [EW-1:0]      w_pushData;
  logic [EW-1:0]      w_head;
  logic [NW-1:0]      w_count;
  logic               w_empty;
  logic               w_pop;
  logic               w_headLast;
  logic [A_BIT-1:0]   w_headAddr0;
  logic [A_BIT-1:0]   w_headAddr1;
  logic [D_BIT-1:0]   w_headY0;
  logic [D_BIT-1:0]   w_headY1;

  // Credit counts buffered pairs plus everything still inside the butterfly.
  always_comb begin
    w_credit = CW'(w_count);
    for (int i = 0; i < BUT_LAT; i++) begin
      w_credit = w_credit + CW'(r_pv[i]);
    end
  end

  assign oREADY   = (w_credit < CW'(DEPTH));
  assign w_accept = iISSUE && oREADY;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_pv    <= '0;
      r_pLast <= '0;
      for (int i = 0; i < BUT_LAT; i++) begin
        r_pAddr0[i] <= '0;
        r_pAddr1[i] <= '0;
      end
    end else begin
      r_pv[0]     <= w_accept;
      r_pLast[0]  <= iLAST;
      r_pAddr0[0] <= iADDR_0;
      r_pAddr1[0] <= iADDR_1;
      for (int i = 1; i < BUT_LAT; i++) begin
        r_pv[i]     <= r_pv[i-1];
        r_pLast[i]  <= r_pLast[i-1];
        r_pAddr0[i] <= r_pAddr0[i-1];
        r_pAddr1[i] <= r_pAddr1[i-1];
      end
    end
  end

  assign w_pushData = {r_pLast[BUT_LAT-1], r_pAddr0[BUT_LAT-1], r_pAddr1[BUT_LAT-1], iY_0, iY_1};

  fht_wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iPUSH  (r_pv[BUT_LAT-1]),
    .iDATA  (w_pushData),
    .iPOP   (w_pop),
    .oHEAD  (w_head),
    .oCOUNT (w_count),
    .oEMPTY (w_empty)
  );

  assign w_headLast  = w_head[EW-1];
  assign w_headAddr0 = w_head[EW-2 -: A_BIT];
  assign w_headAddr1 = w_head[EW-2-A_BIT -: A_BIT];
  assign w_headY0    = w_head[2*D_BIT-1 -: D_BIT];
  assign w_headY1    = w_head[D_BIT-1:0];

  assign oWR_EN = !w_empty;
  assign w_pop  = (r_state == HALF1) && iWR_READY;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= HALF0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        HALF0: begin
          if (oWR_EN && iWR_READY) begin
            r_state <= HALF1;
          end
        end
        HALF1: begin
          if (iWR_READY) begin
            r_state <= HALF0;
            r_done  <= w_headLast;
          end
        end
        default: r_state <= HALF0;
      endcase
    end
  end

  always_comb begin
    oWR_ADDR = '0;
    oWR_DATA = '0;
    if (!w_empty) begin
      if (r_state == HALF0) begin
        oWR_ADDR = w_headAddr0;
        oWR_DATA = w_headY0;
      end else begin
        oWR_ADDR = w_headAddr1;
        oWR_DATA = w_headY1;
      end
    end
  end

  assign oBUSY = (|r_pv) || (w_count != '0);
  assign oDONE = r_done;

endmodule

// File: tb/tb_fht_but_wb.sv
// Scoreboard bench for fht_but_wb: directed issues feed an expected-write queue,
// a negedge monitor checks every accepted RAM write against it.
module tb_fht_but_wb;

  localparam int D_BIT = 17;
  localparam int A_BIT = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [A_BIT-1:0]        addr;
    logic signed [D_BIT-1:0] data;
    logic                    last;
  } exp_t;

  typedef struct packed {
    logic                    valid;
    logic signed [D_BIT-1:0] y0;
    logic signed [D_BIT-1:0] y1;
  } pipe_t;

  typedef struct {
    logic                    wrEn;
    logic                    ready;
    logic                    done;
    logic                    busy;
    logic [A_BIT-1:0]        addr;
    logic signed [D_BIT-1:0] data;
  } snap_t;

  logic                    iCLK;
  logic                    iRESET;
  logic                    iISSUE;
  logic                    iLAST;
  logic [A_BIT-1:0]        iADDR_0;
  logic [A_BIT-1:0]        iADDR_1;
  logic                    oREADY;
  logic signed [D_BIT-1:0] iY_0;
  logic signed [D_BIT-1:0] iY_1;
  logic                    oWR_EN;
  logic [A_BIT-1:0]        oWR_ADDR;
  logic signed [D_BIT-1:0] oWR_DATA;
  logic                    iWR_READY;
  logic                    oBUSY;
  logic                    oDONE;

  int    checks = 0;
  int    errors = 0;
  exp_t  expQ[$];
  pipe_t pipe0, pipe1, pipe2;

  fht_but_wb #(
    .D_BIT (D_BIT),
    .A_BIT (A_BIT),
    .DEPTH (DEPTH)
  ) dut (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iISSUE    (iISSUE),
    .iLAST     (iLAST),
    .iADDR_0   (iADDR_0),
    .iADDR_1   (iADDR_1),
    .oREADY    (oREADY),
    .iY_0      (iY_0),
    .iY_1      (iY_1),
    .oWR_EN    (oWR_EN),
    .oWR_ADDR  (oWR_ADDR),
    .oWR_DATA  (oWR_DATA),
    .iWR_READY (iWR_READY),
    .oBUSY     (oBUSY),
    .oDONE     (oDONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: models the butterfly by replaying operands two cycles later.
  task automatic applyStimulus(input logic issue, input logic last,
                               input logic [A_BIT-1:0] a0, input logic [A_BIT-1:0] a1,
                               input logic signed [D_BIT-1:0] y0,
                               input logic signed [D_BIT-1:0] y1,
                               input logic wrReady, output snap_t s);
    pipe2 = pipe1;
    pipe1 = pipe0;
    pipe0 = '0;
    iY_0      = pipe2.valid ? pipe2.y0 : '0;
    iY_1      = pipe2.valid ? pipe2.y1 : '0;
    iISSUE    = issue;
    iLAST     = last;
    iADDR_0   = a0;
    iADDR_1   = a1;
    iWR_READY = wrReady;
    @(negedge iCLK);
    s.wrEn  = oWR_EN;
    s.ready = oREADY;
    s.done  = oDONE;
    s.busy  = oBUSY;
    s.addr  = oWR_ADDR;
    s.data  = oWR_DATA;
    if (issue && oREADY && !iRESET) begin
      pipe0.valid = 1'b1;
      pipe0.y0    = y0;
      pipe0.y1    = y1;
      expQ.push_back('{addr: a0, data: y0, last: 1'b0});
      expQ.push_back('{addr: a1, data: y1, last: last});
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic drain(input string name);
    snap_t s;
    int    n;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, s);
      n++;
    end while ((expQ.size() != 0 || s.busy) && n < 60);
    checkOutput({name, "_drained"}, (expQ.size() == 0 && !s.busy) ? 1 : 0, 1);
  endtask

  // Monitor: every accepted write must match the queue head; stalls must hold outputs.
  logic                    doneExp   = 1'b0;
  logic                    prevStall = 1'b0;
  logic [A_BIT-1:0]        prevAddr;
  logic signed [D_BIT-1:0] prevData;

  always @(negedge iCLK) begin
    exp_t e;
    if (iRESET) begin
      doneExp   = 1'b0;
      prevStall = 1'b0;
    end else begin
      checkOutput("oDONE", oDONE, doneExp);
      if (prevStall) begin
        checkOutput("holdWrEn", oWR_EN, 1);
        checkOutput("holdAddr", oWR_ADDR, prevAddr);
        checkOutput("holdData", oWR_DATA, prevData);
      end
      doneExp = 1'b0;
      if (oWR_EN && iWR_READY) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedWrite: got addr=0x%0h data=%0d, expected no write",
                   oWR_ADDR, oWR_DATA);
        end else begin
          e = expQ.pop_front();
          checkOutput("wrAddr", oWR_ADDR, e.addr);
          checkOutput("wrData", oWR_DATA, e.data);
          doneExp = e.last;
        end
      end
      prevStall = oWR_EN && !iWR_READY;
      prevAddr  = oWR_ADDR;
      prevData  = oWR_DATA;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    snap_t s;
    logic  expReady [6];

    iRESET    = 1'b1;
    iISSUE    = 1'b0;
    iLAST     = 1'b0;
    iADDR_0   = '0;
    iADDR_1   = '0;
    iY_0      = '0;
    iY_1      = '0;
    iWR_READY = 1'b0;
    pipe0     = '0;
    pipe1     = '0;
    pipe2     = '0;
    repeat (2) @(posedge iCLK);
    #1;
    checkOutput("rst_wrEn", oWR_EN, 0);
    checkOutput("rst_busy", oBUSY, 0);
    checkOutput("rst_ready", oREADY, 1);
    checkOutput("rst_done", oDONE, 0);
    checkOutput("rst_addr", oWR_ADDR, 0);
    checkOutput("rst_data", oWR_DATA, 0);
    iRESET = 1'b0;

    // Single last-tagged issue: writes at t+3 and t+4, done at t+5.
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h90, 17'sd100, -17'sd100, 1'b1, s);
    checkOutput("single_ready", s.ready, 1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, s);
      case (k)
        1, 2: checkOutput("single_noWrEarly", s.wrEn, 0);
        3: begin
          checkOutput("single_wr0En", s.wrEn, 1);
          checkOutput("single_wr0Addr", s.addr, 8'h10);
          checkOutput("single_wr0Data", s.data, 100);
        end
        4: begin
          checkOutput("single_wr1En", s.wrEn, 1);
          checkOutput("single_wr1Addr", s.addr, 8'h90);
          checkOutput("single_wr1Data", s.data, -100);
        end
        default: begin
          checkOutput("single_done", s.done, 1);
          checkOutput("single_busy", s.busy, 0);
        end
      endcase
    end

    // Back-to-back issues: credit runs out on the fifth; that one carries 0x55.
    expReady = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i < 4)
        applyStimulus(1'b1, (i == 3), 8'(8'h20 + i), 8'(8'hA0 + i),
                      17'(i * 10 + 1), 17'(-(i * 10 + 1)), 1'b1, s);
      else
        applyStimulus(1'b1, 1'b0, 8'h55, 8'h56, 17'sd555, 17'sd556, 1'b1, s);
      checkOutput($sformatf("b2b_ready%0d", i), s.ready, expReady[i]);
    end
    drain("b2b");

    // RAM stall from HALF0: credit exhausted, head write held, resumes in order.
    for (int i = 0; i < 10; i++) begin
      if (i < 4)
        applyStimulus(1'b1, 1'b0, 8'(8'h30 + i), 8'(8'hB0 + i),
                      17'(1000 + i), 17'(-2000 - i), 1'b0, s);
      else if (i < 6)
        applyStimulus(1'b1, 1'b0, 8'h55, 8'h57, 17'sd7, 17'sd8, 1'b0, s);
      else
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, s);
      if (i < 6) checkOutput($sformatf("stall_ready%0d", i), s.ready, expReady[i]);
      if (i >= 6) begin
        checkOutput("stall_wrEn", s.wrEn, 1);
        checkOutput("stall_addr", s.addr, 8'h30);
        checkOutput("stall_data", s.data, 1000);
      end
    end
    drain("stall");

    // Stall while in HALF1: Y_1 held, popped only on acceptance.
    applyStimulus(1'b1, 1'b1, 8'h40, 8'hC0, -17'sd7, 17'sd12345, 1'b1, s);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, (k <= 3 || k >= 9), s);
      if (k == 3) checkOutput("mid_wr0Addr", s.addr, 8'h40);
      if (k >= 4 && k <= 9) begin
        checkOutput("mid_holdAddr", s.addr, 8'hC0);
        checkOutput("mid_holdData", s.data, 12345);
        checkOutput("mid_busy", s.busy, 1);
      end
      if (k == 10) begin
        checkOutput("mid_done", s.done, 1);
        checkOutput("mid_wrEnAfter", s.wrEn, 0);
      end
    end

    // Reset with three pairs buffered: everything discarded at once.
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i < 3), 1'b1, 8'(8'h60 + i), 8'(8'hE0 + i),
                    17'(300 + i), 17'(400 + i), 1'b0, s);
    end
    checkOutput("preRst_wrEn", s.wrEn, 1);
    checkOutput("preRst_busy", s.busy, 1);
    iRESET = 1'b1;
    #1;
    checkOutput("midRst_wrEn", oWR_EN, 0);
    checkOutput("midRst_busy", oBUSY, 0);
    checkOutput("midRst_ready", oREADY, 1);
    checkOutput("midRst_done", oDONE, 0);
    expQ.delete();
    pipe0 = '0;
    pipe1 = '0;
    pipe2 = '0;
    @(posedge iCLK);
    #1;
    iRESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, s);
      checkOutput("postRst_noWrite", s.wrEn, 0);
    end

    checkOutput("final_queueEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
